// File: rtl/set_pkg.sv
// Shared definitions for the SET command scheduler: query modes, scheduler
// states and the geometry part of a queued command.
package set_pkg;

    localparam logic [1:0] MODE_A   = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_ILL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // The tag is appended by the scheduler because its width is a parameter there.
    typedef struct packed {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
    } cmd_geom_t;

endpackage

// File: rtl/set_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy; push is ignored when
// full and pop when empty, so callers may drive them unconditionally.
module set_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/set_cmd_sched.sv
// Issues buffered geometry queries one at a time to the SET engine and returns
// each result with its tag; a watchdog turns a silent engine into an error result.
module set_cmd_sched
    import set_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [23:0]            cmd_central,
    input  logic [11:0]            cmd_radius,
    input  logic [1:0]             cmd_mode,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic                   set_en,
    output logic [23:0]            set_central,
    output logic [11:0]            set_radius,
    output logic [1:0]             set_mode,
    input  logic                   set_busy,
    input  logic                   set_valid,
    input  logic [7:0]             set_candidate,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [7:0]             res_candidate,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   res_err,
    output logic [$clog2(DEPTH):0] fifo_level,
    output state_t                 dbg_state
);
    typedef struct packed {
        cmd_geom_t        geom;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    localparam int         CW       = $bits(cmd_t);
    localparam logic [8:0] WD_LIMIT = 9'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_push;
    logic             w_pop;
    logic             w_fire;
    logic             w_capture;
    logic             w_timeout;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_wr_bits;
    logic [CW-1:0]    w_head_bits;
    cmd_t             w_wr;
    cmd_t             w_head;
    logic             r_set_en;
    logic [23:0]      r_central;
    logic [11:0]      r_radius;
    logic [1:0]       r_mode;
    logic [TAG_W-1:0] r_tag;
    logic [8:0]       r_wd;
    logic             r_res_valid;
    logic [7:0]       r_res_cand;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;

    assign w_wr.geom.central = cmd_central;
    assign w_wr.geom.radius  = cmd_radius;
    assign w_wr.geom.mode    = cmd_mode;
    assign w_wr.tag          = cmd_tag;
    assign w_wr_bits         = w_wr;
    assign w_head            = cmd_t'(w_head_bits);
    assign cmd_ready         = ~w_full;
    assign w_push            = cmd_valid & cmd_ready;

    set_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wr_bits),
        .i_pop   (w_pop),
        .o_rdata (w_head_bits),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_fire    = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = (w_head.geom.mode == MODE_ILL) ? ST_HOLD : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!set_busy) begin
                    w_fire = 1'b1;
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (set_valid) begin
                    w_capture = 1'b1;
                    w_next    = ST_HOLD;
                end else if (r_wd == WD_LIMIT) begin
                    w_timeout = 1'b1;
                    w_next    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Issue registers only change on a pop, so the engine sees stable operands
    // from issue until the result is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_set_en    <= 1'b0;
            r_central   <= '0;
            r_radius    <= '0;
            r_mode      <= '0;
            r_tag       <= '0;
            r_wd        <= '0;
            r_res_valid <= 1'b0;
            r_res_cand  <= '0;
            r_res_tag   <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_set_en <= w_fire;
            if (w_pop) begin
                r_central <= w_head.geom.central;
                r_radius  <= w_head.geom.radius;
                r_mode    <= w_head.geom.mode;
                r_tag     <= w_head.tag;
            end
            if (r_state == ST_WAIT && !w_capture && !w_timeout) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
            if (w_pop && w_head.geom.mode == MODE_ILL) begin
                r_res_valid <= 1'b1;
                r_res_cand  <= '0;
                r_res_tag   <= w_head.tag;
                r_res_err   <= 1'b1;
            end else if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_cand  <= set_candidate;
                r_res_tag   <= r_tag;
                r_res_err   <= 1'b0;
            end else if (w_timeout) begin
                r_res_valid <= 1'b1;
                r_res_cand  <= '0;
                r_res_tag   <= r_tag;
                r_res_err   <= 1'b1;
            end else if (r_state == ST_HOLD && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign set_en        = r_set_en;
    assign set_central   = r_central;
    assign set_radius    = r_radius;
    assign set_mode      = r_mode;
    assign res_valid     = r_res_valid;
    assign res_candidate = r_res_cand;
    assign res_tag       = r_res_tag;
    assign res_err       = r_res_err;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_set_cmd_sched.sv
// Self-checking bench for set_cmd_sched with a behavioural SET engine and an
// in-order result scoreboard built from the lattice-point counting rules.
module tb_set_cmd_sched;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [23:0]       cmd_central = '0;
  logic [11:0]       cmd_radius = '0;
  logic [1:0]        cmd_mode = '0;
  logic [TAG_W-1:0]  cmd_tag = '0;
  logic              set_en;
  logic [23:0]       set_central;
  logic [11:0]       set_radius;
  logic [1:0]        set_mode;
  logic              set_busy;
  logic              set_valid = 1'b0;
  logic [7:0]        set_candidate = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [7:0]        res_candidate;
  logic [TAG_W-1:0]  res_tag;
  logic              res_err;
  logic [2:0]        fifo_level;
  set_pkg::state_t   dbg_state;

  set_cmd_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_central(cmd_central),
    .cmd_radius(cmd_radius), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate), .res_valid(res_valid), .res_ready(res_ready),
    .res_candidate(res_candidate), .res_tag(res_tag), .res_err(res_err),
    .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];

  // count of lattice points of the 16x16 grid in A, A and B, or exactly one
  function automatic logic [7:0] set_count(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
    int xa, ya, xb, yb, ra, rb, n;
    bit ia, ib;
    xa = int'(c[23:20]); ya = int'(c[19:16]); xb = int'(c[15:12]); yb = int'(c[11:8]);
    ra = int'(r[11:8]); rb = int'(r[7:4]);
    n = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        ia = ((x - xa) * (x - xa) + (y - ya) * (y - ya)) <= ra * ra;
        ib = ((x - xb) * (x - xb) + (y - yb) * (y - yb)) <= rb * rb;
        case (m)
          2'd0: n = n + (ia ? 1 : 0);
          2'd1: n = n + ((ia && ib) ? 1 : 0);
          2'd2: n = n + ((ia != ib) ? 1 : 0);
          default: n = n;
        endcase
      end
    end
    return n[7:0];
  endfunction

  function automatic logic [12:0] exp_of(input logic [23:0] c, input logic [11:0] r,
                                         input logic [1:0] m, input logic [3:0] t, input bit to);
    if (m == 2'd3 || to) return {1'b1, 8'd0, t};
    return {1'b0, set_count(c, r, m), t};
  endfunction

  function automatic logic [23:0] rand_central();
    return {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'h00};
  endfunction

  function automatic logic [11:0] rand_radius();
    return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'h0};
  endfunction

  // engine model: accepts on set_en, busy for eng_run cycles, then one valid strobe
  logic force_busy = 1'b0;
  logic eng_mute = 1'b0;
  logic e_busy = 1'b0;
  int   eng_run = 2;
  int   e_cnt = 0;
  int   en_count = 0;
  logic [7:0] e_cand = '0;
  assign set_busy = e_busy | force_busy;

  always @(negedge clk) begin
    if (rst) begin
      e_busy = 1'b0; e_cnt = 0; set_valid = 1'b0; set_candidate = '0;
    end else begin
      set_valid = 1'b0;
      if (e_cnt > 0) begin
        e_cnt = e_cnt - 1;
        if (e_cnt == 0) begin
          set_valid = 1'b1; set_candidate = e_cand; e_busy = 1'b0;
        end
      end
      if (set_en) begin
        en_count = en_count + 1;
        if (!eng_mute) begin
          e_busy = 1'b1; e_cnt = eng_run;
          e_cand = set_count(set_central, set_radius, set_mode);
        end
      end
    end
  end

  // result collector: one entry per completed result handshake
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) got_q.push_back({res_err, res_candidate, res_tag});
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                          input logic [3:0] t, input bit to);
    int k = 0;
    cmd_central = c; cmd_radius = r; cmd_mode = m; cmd_tag = t; cmd_valid = 1'b1;
    while (!cmd_ready && k < 400) begin tick(); k++; end
    n_cmp++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL push_accept tag=%0d: cmd_ready still 0 after %0d cycles, required 1", t, k);
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back(exp_of(c, r, m, t, to));
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin tick(); k++; end
  endtask

  task automatic wait_set_en(input int budget);
    int k = 0;
    while (!set_en && k < budget) begin tick(); k++; end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    n_cmp++; if (set_en !== 1'b0) begin n_fail++; $display("FAIL reset_set_en got=%b exp=0", set_en); end
    n_cmp++; if ({set_central, set_radius, set_mode} !== 38'd0) begin
      n_fail++; $display("FAIL reset_set_ops got=%h exp=0", {set_central, set_radius, set_mode}); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    n_cmp++; if ({res_err, res_candidate, res_tag} !== 13'd0) begin
      n_fail++; $display("FAIL reset_res_fields got=%h exp=0", {res_err, res_candidate, res_tag}); end
    n_cmp++; if (dbg_state !== set_pkg::ST_IDLE) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, set_pkg::ST_IDLE); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int e0;
    logic [12:0] g;
    eng_run = 4; res_ready = 1'b1; e0 = en_count;
    push_cmd(24'h44_0000, 12'h300, 2'd0, 4'd5, 1'b0);
    tick();
    n_cmp++; if (set_en !== 1'b0) begin n_fail++; $display("FAIL single_en_t1 got=%b exp=0", set_en); end
    tick();
    n_cmp++; if (set_en !== 1'b1) begin n_fail++; $display("FAIL single_en_t2 got=%b exp=1", set_en); end
    tick();
    n_cmp++; if (set_en !== 1'b0) begin n_fail++; $display("FAIL single_en_t3 got=%b exp=0", set_en); end
    wait_got(1, 100);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL single_count got=%0d exp=1", got_q.size());
    end else begin
      g = got_q.pop_front();
      void'(exp_q.pop_front());
      n_cmp++; if (g !== {1'b0, 8'd29, 4'd5}) begin
        n_fail++; $display("FAIL single_result got=%h exp=%h", g, {1'b0, 8'd29, 4'd5}); end
    end
    exp_q.delete(); got_q.delete();
    n_cmp++; if (en_count - e0 != 1) begin n_fail++; $display("FAIL single_en_pulses got=%0d exp=1", en_count - e0); end
  endtask

  task automatic test_fill();
    int e0;
    logic [12:0] g, e;
    force_busy = 1'b1; res_ready = 1'b1; eng_run = $urandom_range(1, 4); e0 = en_count;
    push_cmd(rand_central(), rand_radius(), 2'($urandom_range(0, 2)), 4'd1, 1'b0);
    tick(); tick();
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL fill_first_popped got=%0d exp=0", fifo_level); end
    for (int i = 1; i <= 4; i++) begin
      push_cmd(rand_central(), rand_radius(), 2'($urandom_range(0, 2)), 4'(i + 1), 1'b0);
      n_cmp++; if (fifo_level !== 3'(i)) begin n_fail++; $display("FAIL fill_level got=%0d exp=%0d", fifo_level, i); end
      n_cmp++; if (cmd_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready got=%b exp=%b", cmd_ready, (i < 4)); end
    end
    fork
      push_cmd(rand_central(), rand_radius(), 2'($urandom_range(0, 2)), 4'd6, 1'b0);
      begin
        repeat (10) tick();
        n_cmp++; if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
          n_fail++; $display("FAIL fill_blocked ready=%b level=%0d exp ready=0 level=4", cmd_ready, fifo_level); end
        n_cmp++; if (en_count != e0) begin n_fail++; $display("FAIL fill_no_issue got=%0d exp=%0d", en_count, e0); end
        force_busy = 1'b0;
      end
    join
    wait_got(6, 600);
    n_cmp++; if (got_q.size() != 6) begin n_fail++; $display("FAIL fill_count got=%0d exp=6", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL fill_result got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_illegal();
    int e0;
    logic [12:0] g, e;
    res_ready = 1'b1; e0 = en_count;
    push_cmd(rand_central(), rand_radius(), 2'd3, 4'd9, 1'b0);
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_early got=%b exp=0", res_valid); end
    tick();
    n_cmp++; if ({res_valid, res_err, res_candidate, res_tag} !== {1'b1, 1'b1, 8'd0, 4'd9}) begin
      n_fail++; $display("FAIL illegal_fields got=%h exp=%h", {res_valid, res_err, res_candidate, res_tag},
                         {1'b1, 1'b1, 8'd0, 4'd9}); end
    wait_got(1, 50);
    repeat (5) tick();
    n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL illegal_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL illegal_result got=%h exp=%h", g, e); end
    end
    n_cmp++; if (en_count != e0) begin n_fail++; $display("FAIL illegal_no_en got=%0d exp=%0d", en_count - e0, 0); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_timeout();
    int e0, k;
    logic [12:0] g, e;
    res_ready = 1'b1; eng_mute = 1'b1; eng_run = 3; e0 = en_count;
    push_cmd(rand_central(), rand_radius(), 2'd0, 4'd3, 1'b1);
    push_cmd(rand_central(), rand_radius(), 2'd2, 4'd4, 1'b0);
    wait_set_en(50);
    n_cmp++; if (set_en !== 1'b1) begin n_fail++; $display("FAIL timeout_issue got=%b exp=1", set_en); end
    force_busy = 1'b1;
    k = 0;
    while (!res_valid && k < 100) begin tick(); k++; end
    eng_mute = 1'b0;
    n_cmp++; if (k != TIMEOUT) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=%0d", k, TIMEOUT); end
    n_cmp++; if (res_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got=%b exp=1", res_err); end
    repeat (15) tick();
    n_cmp++; if (en_count != e0 + 1) begin n_fail++; $display("FAIL timeout_hold_busy got=%0d exp=%0d", en_count - e0, 1); end
    force_busy = 1'b0;
    wait_got(2, 200);
    n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL timeout_count got=%0d exp=2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL timeout_result got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall();
    int e1, k;
    logic [12:0] snap, g, e;
    res_ready = 1'b0; eng_run = 3;
    push_cmd(rand_central(), rand_radius(), 2'($urandom_range(0, 2)), 4'd10, 1'b0);
    k = 0;
    while (!res_valid && k < 100) begin tick(); k++; end
    snap = {res_err, res_candidate, res_tag};
    for (int i = 0; i < 3; i++)
      push_cmd(rand_central(), rand_radius(), 2'($urandom_range(0, 3)), 4'(11 + i), 1'b0);
    e1 = en_count;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++; if (res_valid !== 1'b1 || {res_err, res_candidate, res_tag} !== snap) begin
        n_fail++; $display("FAIL stall_stable cyc=%0d got=%b/%h exp=1/%h", i, res_valid,
                           {res_err, res_candidate, res_tag}, snap); end
    end
    n_cmp++; if (en_count != e1 || fifo_level !== 3'd3) begin
      n_fail++; $display("FAIL stall_no_issue en=%0d level=%0d exp en=0 level=3", en_count - e1, fifo_level); end
    res_ready = 1'b1;
    wait_got(4, 400);
    n_cmp++; if (got_q.size() != 4) begin n_fail++; $display("FAIL stall_count got=%0d exp=4", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL stall_result got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    logic [12:0] g, e;
    fork
      for (int i = 0; i < 24; i++) begin
        eng_run = $urandom_range(1, 5);
        push_cmd(rand_central(), rand_radius(), 2'($urandom_range(0, 3)), 4'(i), 1'b0);
      end
      begin
        for (int k = 0; k < 3000 && got_q.size() < 24; k++) begin
          res_ready = ($urandom_range(0, 2) != 0);
          force_busy = ($urandom_range(0, 3) == 0);
          tick();
        end
        res_ready = 1'b1; force_busy = 1'b0;
      end
    join
    n_cmp++; if (got_q.size() != 24) begin n_fail++; $display("FAIL random_count got=%0d exp=24", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL random_result got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    int seen;
    logic [12:0] g, e;
    res_ready = 1'b1; eng_run = 30;
    for (int i = 0; i < 3; i++)
      push_cmd(rand_central(), rand_radius(), 2'($urandom_range(0, 2)), 4'(i + 2), 1'b0);
    wait_set_en(60);
    tick(); tick();
    n_cmp++; if (dbg_state !== set_pkg::ST_WAIT || fifo_level !== 3'd2) begin
      n_fail++; $display("FAIL rstmid_pre state=%0d level=%0d exp state=2 level=2", dbg_state, fifo_level); end
    rst = 1'b1;
    #1;
    n_cmp++; if (fifo_level !== 3'd0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_fifo level=%0d ready=%b exp 0/1", fifo_level, cmd_ready); end
    n_cmp++; if ({set_en, set_central, set_radius, set_mode} !== 39'd0) begin
      n_fail++; $display("FAIL rstmid_issue got=%h exp=0", {set_en, set_central, set_radius, set_mode}); end
    n_cmp++; if ({res_valid, res_err, res_candidate, res_tag} !== 14'd0) begin
      n_fail++; $display("FAIL rstmid_res got=%h exp=0", {res_valid, res_err, res_candidate, res_tag}); end
    exp_q.delete(); got_q.delete();
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (res_valid || set_en) seen++;
    end
    n_cmp++; if (seen != 0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_quiet got=%0d/%0d exp=0/0", seen, got_q.size()); end
    eng_run = 2;
    push_cmd(rand_central(), rand_radius(), 2'd1, 4'd15, 1'b0);
    wait_got(1, 100);
    n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rstmid_after_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rstmid_after got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_illegal();
    test_timeout();
    test_stall();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
